lsu_wb: RTL and testbench

Load/store unit sitting directly upstream of the register file write port: it accepts one load or store request at a time from the execute stage and runs it on the MMIO data bus (RAM, UART), tolerating variable bus latency. For loads it extracts, extends and writes the result into the register file through its write port. It also reports misaligned, illegal-size and timed-out accesses.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu_wb.sv | 123 ++++++++++++
 tb/tb_lsu_wb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and types for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {StIdle, StBus, StWb, StErr} state_t;

    // True for size 3 or an address not aligned to the access size.
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_ldata = w_shifted;
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_ldata = i_unsigned ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_H: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_ldata = i_unsigned ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_W: o_be = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit: one request at a time on the MMIO bus, load writeback to the
// register file, and error pulses for misaligned, illegal-size or timed-out accesses.
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        err,
    output logic        busy
);

    localparam cnt_t CntLast = cnt_t'(TIMEOUT - 1);

    state_t      r_state, w_state_d;
    cnt_t        r_cnt, w_cnt_d;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rf_wdata;
    logic [4:0]  r_rd;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_bwdata, w_ldata;

    lsu_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rdata    (bus_rdata),
        .o_be       (w_be),
        .o_wdata    (w_bwdata),
        .o_ldata    (w_ldata)
    );

    assign w_accept = (r_state == StIdle) && req_valid;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_cnt_d   = '0;
                    w_state_d = bad_access(req_size, req_addr[1:0]) ? StErr : StBus;
                end
            end
            StBus: begin
                // An ack in the final allowed cycle still completes the access.
                if (bus_ack) begin
                    w_state_d = r_we ? StIdle : StWb;
                end else if (r_cnt == CntLast) begin
                    w_state_d = StErr;
                end else begin
                    w_cnt_d = r_cnt + cnt_t'(1);
                end
            end
            StWb:    w_state_d = StIdle;
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rd    <= req_rd;
            end
            if ((r_state == StBus) && bus_ack && !r_we) begin
                r_rf_wdata <= w_ldata;
            end
        end
    end

    assign req_ready = (r_state == StIdle);
    assign busy      = (r_state != StIdle);
    assign bus_req   = (r_state == StBus);
    assign bus_we    = r_we;
    assign bus_addr  = {r_addr[31:2], 2'b00};
    assign bus_be    = (r_state == StBus) ? w_be : 4'b0000;
    assign bus_wdata = w_bwdata;
    assign rf_we     = (r_state == StWb) && (r_rd != 5'd0);
    assign rf_waddr  = r_rd;
    assign rf_wdata  = r_rf_wdata;
    assign err       = (r_state == StErr);

endmodule

// File: tb/tb_lsu_wb.sv
// Directed, table-driven bench for lsu_wb plus hand-written timeout and reset sequences.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        bus_req, bus_we, bus_ack = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
    logic [3:0]  bus_be;
    logic        rf_we, err, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_wb #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .err          (err),
        .busy         (busy)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic        exp_rfwe;
        logic [31:0] exp_rfwdata;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v);
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;  req_we = v.we;  req_size = v.size;  req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.exp_err) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_no_bus", 32'(bus_req), 32'd0);
            chk("err_no_rfwe", 32'(rf_we), 32'd0);
            @(negedge clk);
            chk("err_clear", 32'(err), 32'd0);
            chk("err_ready", 32'(req_ready), 32'd1);
        end else begin
            chk("bus_req", 32'(bus_req), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("bus_we", 32'(bus_we), 32'(v.we));
            chk("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
            chk("bus_be", 32'(bus_be), 32'(v.exp_be));
            if (v.we) chk("bus_wdata", bus_wdata, v.exp_bwdata);
            repeat (v.waits) begin
                @(negedge clk);
                chk("bus_req_wait", 32'(bus_req), 32'd1);
            end
            bus_ack = 1'b1;
            bus_rdata = v.rdata;
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = '0;
            if (v.we) begin
                chk("st_no_rfwe", 32'(rf_we), 32'd0);
                chk("st_ready", 32'(req_ready), 32'd1);
                chk("st_bus_drop", 32'(bus_req), 32'd0);
            end else begin
                chk("ld_rfwe", 32'(rf_we), 32'(v.exp_rfwe));
                if (v.exp_rfwe) begin
                    chk("ld_waddr", 32'(rf_waddr), 32'(v.rd));
                    chk("ld_wdata", rf_wdata, v.exp_rfwdata);
                end
                chk("ld_not_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                chk("ld_rfwe_clear", 32'(rf_we), 32'd0);
                chk("ld_ready", 32'(req_ready), 32'd1);
            end
        end
    endtask

    initial begin
        //          we    size  uns   addr          wdata         rd     rdata         w  err   be       bwdata        rfwe  rfwdata
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,        5'd5,  32'h8000_0000, 2, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,        5'd5,  32'h8000_0000, 2, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h0000_0080};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hABCD_1234, 5'd0,  32'h0,        1, 1'b0, 4'b1100, 32'h1234_1234, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0,        5'd3,  32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0,        5'd3,  32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,        5'd0,  32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3004, 32'h0,        5'd1,  32'h1122_3344, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h1122_3344};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3008, 32'h0,        5'd2,  32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0,        5'd3,  32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001};
        vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0,        5'd4,  32'h8001_F00D, 0, 1'b0, 4'b0011, 32'h0,        1'b1, 32'h0000_F00D};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h0000_4001, 32'h0000_00A5, 5'd0,  32'h0,        0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h1234_5678, 5'd0,  32'h0,        3, 1'b0, 4'b1111, 32'h1234_5678, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0000_1001, 32'h0,        5'd7,  32'h0000_7F00, 0, 1'b0, 4'b0010, 32'h0,        1'b1, 32'h0000_007F};
        vecs[13] = '{1'b0, 2'd2, 1'b1, 32'h0000_5000, 32'h0,        5'd9,  32'h8000_0001, 0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h8000_0001};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h0000_2001, 32'h0000_BEEF, 5'd0,  32'h0,        0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Timeout: ack withheld, TIMEOUT=8.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_7000; req_rd = 5'd8;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("to_bus_req", 32'(bus_req), 32'd1);
            chk("to_no_err", 32'(err), 32'd0);
            @(negedge clk);
        end
        chk("to_bus_drop", 32'(bus_req), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        chk("to_no_rfwe", 32'(rf_we), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        chk("to_err_clear", 32'(err), 32'd0);
        chk("to_late_ack_rfwe", 32'(rf_we), 32'd0);
        chk("to_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("to_late_ack_rfwe2", 32'(rf_we), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);

        // Reset while in BUS.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_6000; req_rd = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mr_bus_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_bus_drop", 32'(bus_req), 32'd0);
        chk("mr_busy_drop", 32'(busy), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h1234_0000;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        chk("mr_stray_rfwe", 32'(rf_we), 32'd0);
        chk("mr_stray_bus", 32'(bus_req), 32'd0);
        chk("mr_stray_ready", 32'(req_ready), 32'd1);
        run_vec(vecs[6]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
